// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: picks the lowest-id pending mailbox when the bus is
// idle, starts the framer and retires, retries or re-queues on its outcome.
module can_tx_scheduler #(
    parameter int NUM_MBOX  = 4,
    parameter int ID_WIDTH  = 11,
    parameter int MAX_RETRY = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_MBOX-1:0]          req_valid,
    input  logic [NUM_MBOX*ID_WIDTH-1:0] req_id,
    input  logic [NUM_MBOX-1:0]          abort,
    input  logic                         bus_idle,
    input  logic                         tx_done,
    input  logic                         tx_arb_lost,
    input  logic                         tx_error,
    output logic                         tx_start,
    output logic [1:0]                   tx_sel,
    output logic [ID_WIDTH-1:0]          tx_id,
    output logic [NUM_MBOX-1:0]          pending,
    output logic [NUM_MBOX-1:0]          done,
    output logic [NUM_MBOX-1:0]          failed,
    output logic                         busy
);

    localparam int RW = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUS,
        ACTIVE
    } state_t;

    state_t                state_q, state_d;
    logic                  tx_start_q, tx_start_d;
    logic [1:0]            tx_sel_q, tx_sel_d;
    logic [ID_WIDTH-1:0]   tx_id_q, tx_id_d;
    logic [NUM_MBOX-1:0]   pending_q, pending_d;
    logic [NUM_MBOX-1:0]   done_q, done_d;
    logic [NUM_MBOX-1:0]   failed_q, failed_d;
    logic [ID_WIDTH-1:0]   id_q [NUM_MBOX];
    logic [ID_WIDTH-1:0]   id_d [NUM_MBOX];
    logic [RW-1:0]         retry_q [NUM_MBOX];
    logic [RW-1:0]         retry_d [NUM_MBOX];
    logic                  abort_latch_q, abort_latch_d;

    logic                  sel_found;
    logic [1:0]            sel_idx;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  abort_now;

    // Strict less-than keeps ties on the lower index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_id    = '0;
        for (int i = 0; i < NUM_MBOX; i++) begin
            if (pending_q[i] && (!sel_found || id_q[i] < sel_id)) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
                sel_id    = id_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_start_d    = 1'b0;
        tx_sel_d      = tx_sel_q;
        tx_id_d       = tx_id_q;
        pending_d     = pending_q;
        done_d        = '0;
        failed_d      = '0;
        id_d          = id_q;
        retry_d       = retry_q;
        abort_latch_d = abort_latch_q;
        abort_now     = abort_latch_q | abort[tx_sel_q];

        for (int i = 0; i < NUM_MBOX; i++) begin
            if (abort[i]) begin
                if (state_q == ACTIVE && tx_sel_q == 2'(i)) begin
                    abort_latch_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b0;
                end
            end else if (req_valid[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                id_d[i]      = req_id[i*ID_WIDTH +: ID_WIDTH];
                retry_d[i]   = '0;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (|pending_q) state_d = WAIT_BUS;
            end
            WAIT_BUS: begin
                if (pending_q == '0) begin
                    state_d = IDLE;
                end else if (bus_idle && !abort[sel_idx]) begin
                    tx_start_d = 1'b1;
                    tx_sel_d   = sel_idx;
                    tx_id_d    = sel_id;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (tx_done) begin
                    pending_d[tx_sel_q] = 1'b0;
                    done_d[tx_sel_q]    = 1'b1;
                    retry_d[tx_sel_q]   = '0;
                    abort_latch_d       = 1'b0;
                    state_d             = WAIT_BUS;
                end else if (tx_error) begin
                    abort_latch_d = 1'b0;
                    state_d       = WAIT_BUS;
                    if (abort_now || retry_q[tx_sel_q] == RW'(MAX_RETRY)) begin
                        pending_d[tx_sel_q] = 1'b0;
                        failed_d[tx_sel_q]  = 1'b1;
                        retry_d[tx_sel_q]   = '0;
                    end else begin
                        retry_d[tx_sel_q] = retry_q[tx_sel_q] + RW'(1);
                    end
                end else if (tx_arb_lost) begin
                    abort_latch_d = 1'b0;
                    state_d       = WAIT_BUS;
                    if (abort_now) begin
                        pending_d[tx_sel_q] = 1'b0;
                        failed_d[tx_sel_q]  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_start_q    <= 1'b0;
            tx_sel_q      <= '0;
            tx_id_q       <= '0;
            pending_q     <= '0;
            done_q        <= '0;
            failed_q      <= '0;
            id_q          <= '{default: '0};
            retry_q       <= '{default: '0};
            abort_latch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_start_q    <= tx_start_d;
            tx_sel_q      <= tx_sel_d;
            tx_id_q       <= tx_id_d;
            pending_q     <= pending_d;
            done_q        <= done_d;
            failed_q      <= failed_d;
            id_q          <= id_d;
            retry_q       <= retry_d;
            abort_latch_q <= abort_latch_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_sel   = tx_sel_q;
    assign tx_id    = tx_id_q;
    assign pending  = pending_q;
    assign done     = done_q;
    assign failed   = failed_q;
    assign busy     = (state_q == ACTIVE);

endmodule
